// File: rtl/mem_access_stage_pkg.sv
// Shared types for the MEM stage: dword/register types,
// FSM state encoding and RV64 load/store funct3 codes.
package mem_access_stage_pkg;

  localparam int XLEN  = 64;
  localparam int LANES = XLEN / 8;

  typedef logic [XLEN-1:0] dword_t;
  typedef logic [4:0]      reg_t;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } mem_state_t;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LD  = 3'b011;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;
  localparam logic [2:0] LWU = 3'b110;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] SD  = 3'b011;

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between MEM stage
// (master) and the dmem/cache side (slave).
interface mem_access_stage_if;
  import mem_access_stage_pkg::*;

  logic             dmemREN;
  logic             dmemWEN;
  dword_t           dmemaddr;
  dword_t           dmemstore;
  logic [LANES-1:0] dmembyteen;
  logic             dhit;
  dword_t           dmemload;

  modport master (
    output dmemREN,
    output dmemWEN,
    output dmemaddr,
    output dmemstore,
    output dmembyteen,
    input  dhit,
    input  dmemload
  );

  modport slave (
    input  dmemREN,
    input  dmemWEN,
    input  dmemaddr,
    input  dmemstore,
    input  dmembyteen,
    output dhit,
    output dmemload
  );

endinterface

// File: rtl/mem_access_stage_lane_align.sv
// Byte-lane steering: store shift/byte enables, load
// extraction/extension and the natural-alignment check.
module mem_access_stage_lane_align
  import mem_access_stage_pkg::*;
(
  input  logic [2:0]       funct3_i,
  input  logic [2:0]       addr_i,
  input  dword_t           storedata_i,
  input  dword_t           dmemload_i,
  output logic [LANES-1:0] byteen_o,
  output dword_t           store_o,
  output dword_t           load_o,
  output logic             misal_o
);

  logic [2:0]       sz;
  logic [5:0]       bits;
  logic [LANES-1:0] mask;
  dword_t           sh;

  // funct3[1:0] encodes the size for loads and stores alike
  assign sz       = {1'b0, funct3_i[1:0]};
  assign bits     = {addr_i, 3'b000};
  assign store_o  = storedata_i << bits;
  assign sh       = dmemload_i >> bits;
  assign byteen_o = mask << addr_i;

  always_comb begin
    mask    = '0;
    misal_o = 1'b0;
    unique case (sz)
      SB: mask = 8'h01;
      SH: begin
        mask    = 8'h03;
        misal_o = addr_i[0];
      end
      SW: begin
        mask    = 8'h0F;
        misal_o = |addr_i[1:0];
      end
      SD: begin
        mask    = 8'hFF;
        misal_o = |addr_i;
      end
      default: begin
        mask    = 8'hFF;
        misal_o = |addr_i;
      end
    endcase
  end

  always_comb begin
    load_o = sh;
    unique case (funct3_i)
      LB:  load_o = {{(XLEN-8){sh[7]}}, sh[7:0]};
      LH:  load_o = {{(XLEN-16){sh[15]}}, sh[15:0]};
      LW:  load_o = {{(XLEN-32){sh[31]}}, sh[31:0]};
      LD:  load_o = sh;
      LBU: load_o = {{(XLEN-8){1'b0}}, sh[7:0]};
      LHU: load_o = {{(XLEN-16){1'b0}}, sh[15:0]};
      LWU: load_o = {{(XLEN-32){1'b0}}, sh[31:0]};
      default: load_o = sh;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// MEM stage: dmem handshake FSM, stall generation and
// the *_mem inputs of the MEM/WB latch.
module mem_access_stage
  import mem_access_stage_pkg::*;
(
  input  logic   CLK,
  input  logic   nRST,
  input  logic   ex_valid,
  input  logic   MemRead_ex,
  input  logic   MemWrite_ex,
  input  logic   RegWrite_ex,
  input  logic   MemToReg_ex,
  input  reg_t   rd_ex,
  input  logic [2:0] funct3_ex,
  input  dword_t aluout_ex,
  input  dword_t storedata_ex,
  mem_access_stage_if.master dmem,
  output logic   mem_stall,
  output logic   misalign,
  output logic   RegWrite_mem,
  output logic   MemToReg_mem,
  output reg_t   rd_mem,
  output dword_t dmemdata_mem,
  output dword_t aluout_mem
);

  mem_state_t       state_q, state_d;
  dword_t           ldata_q, ldata_d;
  logic             mem_op, is_ld, is_st;
  logic             misal, req_c, mis_c;
  logic             req, wen;
  logic [LANES-1:0] be;
  dword_t           st_al, ld_ext;

  mem_access_stage_lane_align u_align (
    .funct3_i    (funct3_ex),
    .addr_i      (aluout_ex[2:0]),
    .storedata_i (storedata_ex),
    .dmemload_i  (dmem.dmemload),
    .byteen_o    (be),
    .store_o     (st_al),
    .load_o      (ld_ext),
    .misal_o     (misal)
  );

  assign mem_op = ex_valid & (MemRead_ex | MemWrite_ex);
  assign is_ld  = MemRead_ex;
  assign is_st  = MemWrite_ex & ~MemRead_ex;

  always_comb begin
    state_d = state_q;
    ldata_d = ldata_q;
    req_c   = 1'b0;
    mis_c   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_op && misal) begin
          mis_c = 1'b1;
        end else if (mem_op) begin
          req_c   = 1'b1;
          state_d = dmem.dhit ? DONE : REQ;
          if (dmem.dhit) ldata_d = is_ld ? ld_ext : '0;
        end
      end
      REQ: begin
        req_c = 1'b1;
        if (dmem.dhit) begin
          state_d = DONE;
          ldata_d = is_ld ? ld_ext : '0;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      ldata_q <= '0;
    end else begin
      state_q <= state_d;
      ldata_q <= ldata_d;
    end
  end

  // Gate with reset so an abandoned request drops at once
  assign req      = req_c & nRST;
  assign misalign = mis_c & nRST;
  assign wen      = req & is_st;

  assign dmem.dmemREN    = req & is_ld;
  assign dmem.dmemWEN    = wen;
  assign dmem.dmemaddr   = {aluout_ex[XLEN-1:3], 3'b000};
  assign dmem.dmemstore  = wen ? st_al : '0;
  assign dmem.dmembyteen = wen ? be : '0;

  assign mem_stall    = req;
  assign RegWrite_mem = RegWrite_ex & ex_valid
                      & ~req & ~misalign;
  assign MemToReg_mem = MemToReg_ex;
  assign rd_mem       = rd_ex;
  assign aluout_mem   = aluout_ex;
  assign dmemdata_mem = (state_q == DONE) ? ldata_q : '0;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expectations queued
// at issue, compared when the instruction leaves MEM.
module tb_mem_access_stage;
  import mem_access_stage_pkg::*;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       ex_valid, MemRead_ex, MemWrite_ex;
  logic       RegWrite_ex, MemToReg_ex;
  reg_t       rd_ex;
  logic [2:0] funct3_ex;
  dword_t     aluout_ex, storedata_ex;
  logic       mem_stall, misalign;
  logic       RegWrite_mem, MemToReg_mem;
  reg_t       rd_mem;
  dword_t     dmemdata_mem, aluout_mem;

  mem_access_stage_if dmem ();

  mem_access_stage dut (
    .CLK          (CLK),
    .nRST         (nRST),
    .ex_valid     (ex_valid),
    .MemRead_ex   (MemRead_ex),
    .MemWrite_ex  (MemWrite_ex),
    .RegWrite_ex  (RegWrite_ex),
    .MemToReg_ex  (MemToReg_ex),
    .rd_ex        (rd_ex),
    .funct3_ex    (funct3_ex),
    .aluout_ex    (aluout_ex),
    .storedata_ex (storedata_ex),
    .dmem         (dmem),
    .mem_stall    (mem_stall),
    .misalign     (misalign),
    .RegWrite_mem (RegWrite_mem),
    .MemToReg_mem (MemToReg_mem),
    .rd_mem       (rd_mem),
    .dmemdata_mem (dmemdata_mem),
    .aluout_mem   (aluout_mem)
  );

  always #5 CLK = ~CLK;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic   rw;
    reg_t   rd;
    dword_t data;
    dword_t alu;
    logic   mis;
  } exp_t;

  exp_t sb[$];

  always @(negedge CLK) begin : mon
    exp_t e;
    if (nRST && ex_valid && !mem_stall) begin
      chk("sb_pop", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("misalign", misalign, e.mis);
        chk("regwrite", RegWrite_mem, e.rw);
        chk("rd_mem", rd_mem, e.rd);
        chk("ldata", dmemdata_mem, e.data);
        chk("aluout", aluout_mem, e.alu);
      end
    end
  end

  task automatic run(input logic r, input logic w,
                     input logic rw, input reg_t rd,
                     input logic [2:0] f3,
                     input dword_t alu, input dword_t sd,
                     input dword_t ld, input int hit_k,
                     input dword_t edata, input logic emis,
                     input int estall, input logic [7:0] ebe,
                     input dword_t est);
    int   k    = 0;
    int   st   = 0;
    int   hold = 0;
    logic done = 1'b0;
    exp_t e;
    @(posedge CLK); #1;
    ex_valid      = 1'b1;
    MemRead_ex    = r;
    MemWrite_ex   = w;
    RegWrite_ex   = rw;
    MemToReg_ex   = r;
    rd_ex         = rd;
    funct3_ex     = f3;
    aluout_ex     = alu;
    storedata_ex  = sd;
    dmem.dmemload = ld;
    e.rw   = rw & ~emis;
    e.rd   = rd;
    e.data = edata;
    e.alu  = alu;
    e.mis  = emis;
    sb.push_back(e);
    while (!done && k < 40) begin
      dmem.dhit = (k == hit_k);
      @(negedge CLK); #1;
      if (k == 0) begin
        chk("req", dmem.dmemREN | dmem.dmemWEN,
            64'(estall > 0));
        if (estall > 0) begin
          chk("ren", dmem.dmemREN, r);
          chk("addr", dmem.dmemaddr, {alu[63:3], 3'b000});
          chk("byteen", dmem.dmembyteen, ebe);
          chk("store", dmem.dmemstore, est);
        end
      end
      if (mem_stall) begin
        st++;
        if (dmem.dmemREN | dmem.dmemWEN) hold++;
      end else begin
        done = 1'b1;
        chk("done_req", dmem.dmemREN | dmem.dmemWEN, 0);
      end
      if (!done) begin
        @(posedge CLK); #1;
        k++;
      end
    end
    dmem.dhit = 1'b0;
    chk("done", done, 1);
    chk("stall_cyc", 64'(st), 64'(estall));
    chk("req_hold", 64'(hold), 64'(estall));
  endtask

  initial begin
    nRST          = 1'b0;
    ex_valid      = 1'b0;
    MemRead_ex    = 1'b0;
    MemWrite_ex   = 1'b0;
    RegWrite_ex   = 1'b0;
    MemToReg_ex   = 1'b0;
    rd_ex         = '0;
    funct3_ex     = '0;
    aluout_ex     = '0;
    storedata_ex  = '0;
    dmem.dhit     = 1'b0;
    dmem.dmemload = '0;
    #2;
    chk("rst_ren", dmem.dmemREN, 0);
    chk("rst_wen", dmem.dmemWEN, 0);
    chk("rst_be", dmem.dmembyteen, 0);
    chk("rst_stall", mem_stall, 0);
    chk("rst_mis", misalign, 0);
    chk("rst_ldata", dmemdata_mem, 0);
    @(negedge CLK);
    nRST = 1'b1;

    run(0, 1, 0, 5'd0, SD, 64'h1000,
        64'hDEADBEEF_CAFEF00D, 64'h0, 2,
        64'h0, 0, 3, 8'hFF, 64'hDEADBEEF_CAFEF00D);
    run(1, 0, 1, 5'd5, LB, 64'h2003, 64'h0,
        64'h00000000_80000000, 1,
        64'hFFFFFFFF_FFFFFF80, 0, 2, 8'h00, 64'h0);
    run(1, 0, 1, 5'd6, LBU, 64'h2003, 64'h0,
        64'h00000000_80000000, 0,
        64'h80, 0, 1, 8'h00, 64'h0);
    run(0, 1, 0, 5'd0, SH, 64'h3006, 64'h1234,
        64'h0, 0, 64'h0, 0, 1, 8'hC0,
        64'h1234_0000_0000_0000);
    run(1, 0, 1, 5'd9, LW, 64'h4002, 64'h0,
        64'hFFFF_FFFF_FFFF_FFFF, 0,
        64'h0, 1, 0, 8'h00, 64'h0);
    run(0, 0, 1, 5'd7, 3'b000, 64'h55, 64'h0,
        64'h0, 0, 64'h0, 0, 0, 8'h00, 64'h0);
    run(1, 0, 1, 5'd10, LH, 64'h2006, 64'h0,
        64'hBEEF_0000_0000_0000, 0,
        64'hFFFFFFFF_FFFFBEEF, 0, 1, 8'h00, 64'h0);
    run(1, 0, 1, 5'd11, LHU, 64'h2006, 64'h0,
        64'hBEEF_0000_0000_0000, 1,
        64'h0000_0000_0000_BEEF, 0, 2, 8'h00, 64'h0);
    run(1, 0, 1, 5'd12, LWU, 64'h2004, 64'h0,
        64'h80000001_12345678, 0,
        64'h00000000_80000001, 0, 1, 8'h00, 64'h0);
    run(1, 0, 1, 5'd13, LW, 64'h2004, 64'h0,
        64'h80000001_12345678, 0,
        64'hFFFFFFFF_80000001, 0, 1, 8'h00, 64'h0);
    run(0, 1, 0, 5'd0, SW, 64'h1004,
        64'h11223344_AABBCCDD, 64'h0, 0,
        64'h0, 0, 1, 8'hF0, 64'hAABBCCDD_00000000);
    run(0, 1, 0, 5'd0, SB, 64'h1007,
        64'h11111111_1111115A, 64'h0, 3,
        64'h0, 0, 4, 8'h80, 64'h5A00_0000_0000_0000);
    run(0, 1, 0, 5'd0, SD, 64'h1004, 64'h77,
        64'h0, 0, 64'h0, 1, 0, 8'h00, 64'h0);
    run(1, 0, 1, 5'd14, LH, 64'h2001, 64'h0,
        64'h0, 0, 64'h0, 1, 0, 8'h00, 64'h0);
    run(1, 0, 1, 5'd15, 3'b111, 64'h2008, 64'h0,
        64'h01234567_89ABCDEF, 0,
        64'h01234567_89ABCDEF, 0, 1, 8'h00, 64'h0);

    // reset while a load waits in REQ
    @(posedge CLK); #1;
    ex_valid      = 1'b1;
    MemRead_ex    = 1'b1;
    MemWrite_ex   = 1'b0;
    RegWrite_ex   = 1'b1;
    MemToReg_ex   = 1'b1;
    rd_ex         = 5'd3;
    funct3_ex     = LD;
    aluout_ex     = 64'h5000;
    dmem.dhit     = 1'b0;
    @(negedge CLK); #1;
    chk("pre_ren", dmem.dmemREN, 1);
    @(posedge CLK); #1;
    chk("req_ren", dmem.dmemREN, 1);
    chk("req_stall", mem_stall, 1);
    nRST = 1'b0;
    #1;
    chk("mid_ren", dmem.dmemREN, 0);
    chk("mid_wen", dmem.dmemWEN, 0);
    chk("mid_stall", mem_stall, 0);
    chk("mid_be", dmem.dmembyteen, 0);
    chk("mid_mis", misalign, 0);
    chk("mid_ldata", dmemdata_mem, 0);
    ex_valid = 1'b0;
    @(negedge CLK);
    nRST = 1'b1;

    run(1, 0, 1, 5'd3, LD, 64'h5000, 64'h0,
        64'hFEDCBA98_76543210, 0,
        64'hFEDCBA98_76543210, 0, 1, 8'h00, 64'h0);

    @(posedge CLK); #1;
    ex_valid = 1'b0;
    repeat (2) @(posedge CLK);
    chk("sb_drained", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM stage of the 64-bit RISC-V pipeline.
- Consumes EX/MEM latch outputs and runs the data-memory request/response handshake.
- Aligns store data and byte enables; extracts and extends load data.
- Drives the *_mem inputs of the MEM/WB latch and holds the pipeline (mem_stall) until the access completes.

Parameters:
XLEN, 64, datapath/address width in bits
LANES, 8, byte lanes per dmem dword (XLEN/8)

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  asynchronous active-low reset
ex_valid  input  1  valid instruction present in MEM
MemRead_ex  input  1  load
MemWrite_ex  input  1  store
RegWrite_ex  input  1  instruction writes rd
MemToReg_ex  input  1  writeback source is memory
rd_ex  input  5 (reg_t)  destination register
funct3_ex  input  3  access size/sign (RV64 load/store encoding)
aluout_ex  input  XLEN (dword_t)  effective address or ALU result
storedata_ex  input  XLEN  rs2 value, low bytes significant
dhit  input  1  dmem completes the current request this cycle
dmemload  input  XLEN  dmem read dword, valid with dhit
dmemREN  output  1  read request
dmemWEN  output  1  write request
dmemaddr  output  XLEN  dword-aligned address {addr[63:3],3'b0}
dmemstore  output  XLEN  lane-aligned store data
dmembyteen  output  LANES  store byte enables
mem_stall  output  1  freeze PC/IF/ID/EX/MEM latches and the MEM/WB latch enable
misalign  output  1  one-cycle pulse on a misaligned access
RegWrite_mem, MemToReg_mem  output  1 each  to MEM/WB latch
rd_mem  output  5  to MEM/WB latch
dmemdata_mem  output  XLEN  extended load data to MEM/WB latch
aluout_mem  output  XLEN  aluout_ex pass-through

Behaviour:
- Clocking and reset: one clock, CLK. nRST is asynchronous and active-low.
- Reset values:
  - State returns to IDLE.
  - dmemREN, dmemWEN, mem_stall, misalign are 0; dmembyteen is 0.
  - The load-data register is 0.
  - Reset mid-request abandons the access; the dmem request drops immediately.
- mem_op = ex_valid & (MemRead_ex | MemWrite_ex). MemRead_ex and MemWrite_ex both high is illegal; the load takes priority.
- Non-memory ops: zero latency, mem_stall = 0.
  - RegWrite_mem = RegWrite_ex & ex_valid; rd_mem and aluout_mem pass through.
  - dmemdata_mem = 0.
- Alignment check: byte is always aligned; half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
- Misaligned mem_op:
  - No dmem request is issued.
  - misalign = 1 for that cycle; RegWrite_mem forced 0; mem_stall = 0.
- FSM states are IDLE, REQ, DONE.
- IDLE:
  - On an aligned mem_op, assert REN/WEN combinationally and set mem_stall = 1.
  - If dhit is high the same cycle, capture the load and go to DONE; otherwise go to REQ.
- REQ:
  - REN/WEN, dmemaddr, dmemstore and dmembyteen are held stable; mem_stall = 1.
  - On dhit, register the extended load data and go to DONE.
- DONE:
  - No request; mem_stall = 0; dmemdata_mem comes from the register; RegWrite_mem = RegWrite_ex.
  - The pipeline advances at this edge; the state returns to IDLE.
  - This state blocks re-issue of the same instruction.
- Minimum memory-op latency is 2 cycles (request + DONE); each extra dhit wait adds 1.
- Store lanes (funct3): SB=000 sets 1 lane at addr[2:0]; SH=001 sets 2; SW=010 sets 4; SD=011 sets 8. Store data is shifted left by addr[2:0]*8.
- Loads take dmemload >> (addr[2:0]*8), then extend:
  - Sign-extended: LB, LH, LW, LD.
  - Zero-extended: LBU=100, LHU=101, LWU=110.
  - funct3 111 is treated as LD.
- Loads drive dmembyteen = 0. dmemstore is don't-care when WEN=0 and is driven 0.

Decomposition:
- types_pkg additions:
  - mem_state_t enum {IDLE, REQ, DONE}.
  - funct3 constants LB..LWU, SB..SD.
  - Existing dword_t/reg_t.
- Sub-module lane_align (combinational): inputs funct3, addr[2:0], storedata, dmemload; outputs byteen, aligned store, extended load, misaligned flag. Shared by both paths.

Test Plan:
- SD to 0x1000 with data 0xDEADBEEF_CAFEF00D, dhit after 3 cycles -> WEN held 3 cycles; byteen=0xFF; mem_stall high 3 cycles then low in DONE; RegWrite_mem=0.
- LB from 0x2003 where dmemload=0x00000000_80000000 -> dmemdata_mem=0xFFFFFFFF_FFFFFF80; LBU from the same address -> 0x80.
- SH to 0x3006 with data 0x1234 -> dmemaddr=0x3000; byteen=0xC0; dmemstore[63:48]=0x1234.
- LW from 0x4002 -> misalign pulses 1; no REN; RegWrite_mem=0; mem_stall=0.
- ADD (no mem op) with aluout=0x55, rd=7 -> same-cycle RegWrite_mem=1, rd_mem=7, aluout_mem=0x55, stall=0.
- nRST low while in REQ (LD from 0x5000) -> REN drops immediately; outputs at reset values; after release an LD issues cleanly; dhit same cycle -> 2-cycle latency.
